// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: first-word-fall-through byte FIFO between the UART receiver and transmitter, with drop-on-full reporting.
// Optional macro UART_FIFO_LINE_MODE_EN holds the output back until a complete line (CR or LF) is buffered.
module uart_byte_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic                  push;
    logic                  pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign drop     = in_valid && full;
    assign count    = count_q;

    // The RAM is never cleared, so the head is masked to zero while nothing is stored.
    assign out_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push && !reset) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef UART_FIFO_LINE_MODE_EN
    function automatic logic is_eol(input logic [DATA_WIDTH-1:0] d);
        return (d == DATA_WIDTH'(8'h0A)) || (d == DATA_WIDTH'(8'h0D));
    endfunction

    logic [CW-1:0] lines;
    logic          push_eol;
    logic          pop_eol;

    assign push_eol = push && is_eol(in_data);
    assign pop_eol  = pop && is_eol(mem[rd_ptr]);

    always_ff @(posedge clock) begin
        if (reset) begin
            lines <= '0;
        end else if (push_eol && !pop_eol) begin
            lines <= lines + 1'b1;
        end else if (!push_eol && pop_eol) begin
            lines <= lines - 1'b1;
        end
    end

    // Releasing on full keeps a line longer than DEPTH from deadlocking the echo path.
    assign out_valid = !empty && ((lines != '0) || full);
`else
    assign out_valid = !empty;
`endif

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Self-checking bench for uart_byte_fifo: queue-based reference model checked every cycle plus directed literal checks.
// Covers the default build and, when UART_FIFO_LINE_MODE_EN is defined, line-release behaviour.
module tb_uart_byte_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clock = 1'b0;
    logic          reset;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          drop;

    int n_checks = 0;
    int n_fail   = 0;
    logic live = 1'b0;

    logic [DW-1:0] model_q[$];

    uart_byte_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .drop      (drop)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_has_eol();
        foreach (model_q[i]) begin
            if (model_q[i] == 8'h0A || model_q[i] == 8'h0D) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic exp_out_valid();
`ifdef UART_FIFO_LINE_MODE_EN
        return (model_q.size() != 0) && (model_has_eol() || model_q.size() == DEPTH);
`else
        return model_q.size() != 0;
`endif
    endfunction

    // Reference model: a queue of stored bytes, updated on each rising edge.
    always @(posedge clock) begin
        if (reset) begin
            model_q.delete();
            live <= 1'b1;
        end else if (in_valid && model_q.size() < DEPTH) begin
            if (exp_out_valid() && out_ready) void'(model_q.pop_front());
            model_q.push_back(in_data);
        end else if (exp_out_valid() && out_ready) begin
            void'(model_q.pop_front());
        end
    end

    always @(negedge clock) begin
        if (live) begin
            check("count",     32'(count),     32'(model_q.size()));
            check("full",      32'(full),      32'(model_q.size() == DEPTH));
            check("empty",     32'(empty),     32'(model_q.size() == 0));
            check("in_ready",  32'(in_ready),  32'(model_q.size() != DEPTH));
            check("out_valid", 32'(out_valid), 32'(exp_out_valid()));
            check("drop",      32'(drop),      32'(in_valid && model_q.size() == DEPTH));
            if (exp_out_valid()) check("out_data", 32'(out_data), 32'(model_q[0]));
            if (model_q.size() == 0) check("out_data_empty", 32'(out_data), 32'h0);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_count",    32'(count),     32'd0);
        check("rst_empty",    32'(empty),     32'd1);
        check("rst_full",     32'(full),      32'd0);
        check("rst_in_ready", 32'(in_ready),  32'd1);
        check("rst_out_valid",32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data),  32'd0);
        check("rst_drop",     32'(drop),      32'd0);

`ifndef UART_FIFO_LINE_MODE_EN
        // Single push, one-cycle latency to output
        in_data = 8'h30; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t1_out_valid", 32'(out_valid), 32'd1);
        check("t1_out_data",  32'(out_data),  32'h30);
        check("t1_count",     32'(count),     32'd1);
        check("t1_empty",     32'(empty),     32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t1_drained", 32'(empty), 32'd1);

        // Fill to DEPTH, then overflow
        for (int i = 1; i <= DEPTH; i++) begin
            in_data = 8'(i); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("t2_full",     32'(full),     32'd1);
        check("t2_in_ready", 32'(in_ready), 32'd0);
        check("t2_count",    32'(count),    32'd16);
        in_data = 8'hAA; in_valid = 1'b1;
        #1;
        check("t2_drop", 32'(drop), 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        check("t2_drop_clear", 32'(drop),  32'd0);
        check("t2_count_hold", 32'(count), 32'd16);

        // Drain in order
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check("t3_order", 32'(out_data), 32'(i + 1));
            tick();
        end
        out_ready = 1'b0;
        check("t3_empty",     32'(empty),     32'd1);
        check("t3_out_valid", 32'(out_valid), 32'd0);

        // 20-word stream through the pointer wrap
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) check("t3_stream", 32'(out_data), 32'(8'h50 + i - 1));
            in_data = 8'(8'h50 + i); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("t3_stream_last", 32'(out_data), 32'h63);
        tick();
        out_ready = 1'b0;
        check("t3_stream_empty", 32'(count), 32'd0);

        // Steady push+pop at count=5
        for (int i = 0; i < 5; i++) begin
            in_data = 8'(8'h60 + i); in_valid = 1'b1;
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("t4_order", 32'(out_data), 32'(8'h60 + i));
            in_data = 8'(8'h65 + i);
            tick();
            check("t4_count", 32'(count), 32'd5);
        end
        in_valid = 1'b0; out_ready = 1'b0;

        // Reset mid-operation with count=7
        in_data = 8'h70; in_valid = 1'b1; tick();
        in_data = 8'h71; tick();
        in_valid = 1'b0;
        check("t5_count7", 32'(count), 32'd7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_count",     32'(count),     32'd0);
        check("t5_empty",     32'(empty),     32'd1);
        check("t5_out_valid", 32'(out_valid), 32'd0);
        in_data = 8'h41; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t5_first", 32'(out_data), 32'h41);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
`else
        // Line release on CR
        in_data = 8'h41; in_valid = 1'b1; tick();
        in_data = 8'h42; tick();
        in_valid = 1'b0;
        check("t6_hold", 32'(out_valid), 32'd0);
        check("t6_count", 32'(count), 32'd2);
        in_data = 8'h0D; in_valid = 1'b1; tick();
        in_valid = 1'b0;
        check("t6_release", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        check("t6_a", 32'(out_data), 32'h41); tick();
        check("t6_b", 32'(out_data), 32'h42); tick();
        check("t6_cr", 32'(out_data), 32'h0D); tick();
        out_ready = 1'b0;
        check("t6_done", 32'(out_valid), 32'd0);
        // Full escape for an unterminated line
        for (int i = 0; i < DEPTH; i++) begin
            in_data = 8'(8'h41 + i); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("t6_full",      32'(full),      32'd1);
        check("t6_full_valid",32'(out_valid), 32'd1);
        check("t6_full_data", 32'(out_data),  32'h41);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t6_regate", 32'(out_valid), 32'd0);
        check("t6_count15", 32'(count), 32'd15);
        reset = 1'b1; tick(); reset = 1'b0;
        check("t6_reset", 32'(count), 32'd0);
`endif

        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
